uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side buffer for the UART path. It sits between the `uartRx` outputs (`rdata`, `rdata_valid`, `rdata_error`) and the consuming logic. It turns each rising edge of `rdata_valid` into one write of data plus error flag into an internal first-word-fall-through FIFO, and counts bytes dropped on overflow. It also flags end-of-frame after a configurable line-idle gap, for example the Modbus-RTU 3.5-character gap.

## Interface
- `CLK_FREQ_MHZ`, 100: clock frequency in MHz.
- `BAUD`, 115200: line baud rate.
- `DATA_BITS`, 8: receiver data width, 5..8.
- `ADDR_WIDTH`, 5: FIFO depth = 2^ADDR_WIDTH.
- `ALMOST_FULL_LEVEL`, 28: `fifo_almost_full` asserts when count ≥ this value.
- `IDLE_BITS`, 35: idle gap in bit times before `frame_end`.
- `clk`  in  1  single clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `rdata`  in  DATA_BITS  received byte from the receiver.
- `rdata_valid`  in  1  rising edge marks a new byte.
- `rdata_error`  in  1  error flag for the byte, sampled with the `rdata_valid` edge.
- `fifo_dout`  out  8  head entry, zero-extended; 0 when empty.
- `fifo_dout_error`  out  1  head entry's error flag; 0 when empty.
- `fifo_rd_en`  in  1  pop the head entry.
- `fifo_empty`  out  1  FIFO empty.
- `fifo_full`  out  1  count = 2^ADDR_WIDTH.
- `fifo_almost_full`  out  1  count ≥ ALMOST_FULL_LEVEL.
- `fifo_count`  out  ADDR_WIDTH+1  number of stored entries.
- `overflow`  out  1  sticky; set when a byte is dropped.
- `overflow_clr`  in  1  clears `overflow` and `drop_cnt`.
- `drop_cnt`  out  16  dropped bytes, saturates at 0xFFFF.
- `frame_end`  out  1  one-cycle pulse after the idle gap.

## Operation
- **Edge detect.** `valid_d` is a registered copy of `rdata_valid`.
  - Write strobe: `wr = rdata_valid & ~valid_d`.
  - `valid_d` resets to 1, so a `rdata_valid` held high across reset release creates no write.
- **Write path.**
  - On `wr` when not full: store `{rdata_error, rdata}` at the write pointer, then increment the write pointer.
  - On `wr` when full and no pop in the same cycle: the byte is dropped, `overflow` is set, and `drop_cnt` increments (saturating).
  - On `wr` when full with a valid pop in the same cycle: the write is accepted and the count stays at 2^ADDR_WIDTH.
- **Read path.**
  - `fifo_rd_en` while not empty pops the head entry.
  - `fifo_rd_en` while empty is ignored.
  - Simultaneous write and pop: count is unchanged.
- **Pointers.** ADDR_WIDTH bits each, wrapping naturally; the count is tracked separately.
- **Overflow clear.** `overflow_clr` clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the set wins: `overflow`=1 and `drop_cnt`=1.
- **Idle timer.**
  - BIT_CYCLES = round(CLK_FREQ_MHZ·10^6 / BAUD); IDLE_CYCLES = BIT_CYCLES·IDLE_BITS.
  - Counter width is clog2(IDLE_CYCLES+1).
  - State **DISARMED**: counter held at 0. Any `wr` (accepted or dropped) moves the timer to ARMED with counter = 0.
  - State **ARMED**: counter increments each cycle. At IDLE_CYCLES−1, `frame_end` pulses for one cycle and the timer returns to DISARMED.
  - A `wr` in ARMED restarts the count at 0, including on the terminal cycle; the restart takes priority and no pulse is issued.
- **Reset.** Clears pointers, count, `overflow`, `drop_cnt` and the timer (DISARMED), and sets `valid_d`=1. Memory contents are not cleared. A reset mid-frame discards all buffered data and any pending `frame_end`.

## Timing
- **Reset values:** `fifo_empty`=1, `fifo_full`=0, `fifo_almost_full`=0, `fifo_count`=0, `fifo_dout`=0, `fifo_dout_error`=0, `overflow`=0, `drop_cnt`=0, `frame_end`=0.
- **Write latency.** Let C be the cycle in which `wr`=1. The entry is committed at the end of C. In C+1, `fifo_empty`=0 and the entry is visible on `fifo_dout` if the FIFO was empty.
- **Read latency.** A pop in cycle R removes the head entry at the end of R. The next entry, or `fifo_empty`=1, appears in R+1.
- **Registered flags.** `fifo_count`, `fifo_full`, `fifo_almost_full`, `overflow` and `drop_cnt` are registered and update in C+1 / R+1.
- **`fifo_dout` timing.** `fifo_dout` and `fifo_dout_error` derive combinationally from the read pointer and `fifo_empty`.
- **`frame_end` timing.** With C the last `wr` cycle, `frame_end` is high in cycle C+IDLE_CYCLES.

## Test plan
- **Basic write/read.** Reset, then raise `rdata_valid` with `rdata`=0xA5, `rdata_error`=0 and hold it high for 5 cycles. Required: exactly one entry, `fifo_count`=1, `fifo_dout`=0xA5. Pop it: `fifo_empty`=1 and `fifo_dout`=0.
- **Overflow and clear** (ADDR_WIDTH=2, ALMOST_FULL_LEVEL=3). Write 0x01..0x06 with no reads. Required:
  - `fifo_almost_full` after the 3rd write; `fifo_full` after the 4th.
  - `overflow`=1 and `drop_cnt`=2.
  - Pops return 0x01, 0x02, 0x03, 0x04.
  - Pulse `overflow_clr`: `drop_cnt`=0.
- **Simultaneous events** (ADDR_WIDTH=2, FIFO full).
  - `wr` of 0x07 in the same cycle as `fifo_rd_en`: accepted, count stays 4, `drop_cnt` unchanged.
  - `overflow_clr` coincident with a drop: `overflow`=1, `drop_cnt`=1.
- **Error flag and reset edge case.** Write 0x3C with `rdata_error`=1: `fifo_dout_error`=1. Hold `rdata_valid` high through reset release: no write occurs.
- **Idle gap** (CLK_FREQ_MHZ=10, BAUD=1000000, IDLE_BITS=35, so IDLE_CYCLES=350).
  - Bytes 200 cycles apart with the last `wr` at cycle C: a single `frame_end` at C+350 and none earlier.
  - A byte arriving at C+349 suppresses the pulse and restarts the count.
- **Reset mid-operation.** With 3 entries buffered and the timer ARMED, assert `rstn`=0 for one cycle. Required: `fifo_empty`=1, `fifo_count`=0, no `frame_end` afterwards.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// Receive-side FWFT buffer behind the UART receiver: edge-detected writes, overflow
// accounting with a saturating drop counter, and an end-of-frame pulse after a line-idle gap.
module uart_rx_buffer #(
  parameter int unsigned CLK_FREQ_MHZ      = 100,
  parameter int unsigned BAUD              = 115200,
  parameter int unsigned DATA_BITS         = 8,
  parameter int unsigned ADDR_WIDTH        = 5,
  parameter int unsigned ALMOST_FULL_LEVEL = 28,
  parameter int unsigned IDLE_BITS         = 35
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_BITS-1:0]  rdata,
  input  logic                  rdata_valid,
  input  logic                  rdata_error,
  output logic [7:0]            fifo_dout,
  output logic                  fifo_dout_error,
  input  logic                  fifo_rd_en,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_almost_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic [15:0]           drop_cnt,
  output logic                  frame_end
);

  localparam int unsigned Depth      = 1 << ADDR_WIDTH;
  localparam int unsigned BitCycles  = (CLK_FREQ_MHZ * 1000000 + BAUD / 2) / BAUD;
  localparam int unsigned IdleCycles = BitCycles * IDLE_BITS;
  localparam int unsigned CntW       = $clog2(IdleCycles + 1);

  localparam logic [ADDR_WIDTH:0]   CountFull = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0]   CountAf   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CountOne  = 1;
  localparam logic [ADDR_WIDTH-1:0] PtrOne    = 1;
  localparam logic [CntW-1:0]       CntLast   = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0]       CntOne    = 1;

  typedef enum logic [0:0] {StDisarmed, StArmed} timer_state_e;

  logic                   valid_q;
  logic [ADDR_WIDTH-1:0]  wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   full_q, af_q;
  logic                   ovf_q, ovf_d;
  logic [15:0]            drop_q, drop_d;
  logic [DATA_BITS:0]     mem [Depth];
  logic [DATA_BITS:0]     head;
  logic                   wr, pop, push, drop;
  timer_state_e           state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign wr         = rdata_valid & ~valid_q;
  assign fifo_empty = (count_q == '0);
  assign pop        = fifo_rd_en & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign push       = wr & (~full_q | pop);
  assign drop       = wr & full_q & ~pop;
  assign head       = mem[rptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CountOne;
    end else if (!push && pop) begin
      count_d = count_q - CountOne;
    end
  end

  // A coincident drop beats the clear, leaving a count of exactly one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (overflow_clr) begin
        drop_d = 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (overflow_clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      valid_q <= rdata_valid;
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      count_q <= count_d;
      full_q  <= (count_d == CountFull);
      af_q    <= (count_d >= CountAf);
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {rdata_error, rdata};
  end

  always_comb begin
    fifo_dout       = '0;
    fifo_dout_error = 1'b0;
    if (!fifo_empty) begin
      fifo_dout[DATA_BITS-1:0] = head[DATA_BITS-1:0];
      fifo_dout_error          = head[DATA_BITS];
    end
  end

  assign fifo_full        = full_q;
  assign fifo_almost_full = af_q;
  assign fifo_count       = count_q;
  assign overflow         = ovf_q;
  assign drop_cnt         = drop_q;

  // Idle-gap timer
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StDisarmed;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StDisarmed: begin
        cnt_d = '0;
        if (wr) state_d = StArmed;
      end
      StArmed: begin
        if (wr) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StDisarmed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StDisarmed;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    frame_end = rstn && (state_q == StArmed) && !wr && (cnt_q == CntLast);
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed, table-driven bench for uart_rx_buffer with a 4-deep FIFO and a 350-cycle idle gap.
module tb_uart_rx_buffer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rdata;
  logic          rdata_valid, rdata_error, fifo_rd_en, overflow_clr;
  logic [7:0]    fifo_dout;
  logic          fifo_dout_error, fifo_empty, fifo_full, fifo_almost_full, overflow, frame_end;
  logic [AW:0]   fifo_count;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_buffer #(
    .CLK_FREQ_MHZ      (10),
    .BAUD              (1000000),
    .DATA_BITS         (8),
    .ADDR_WIDTH        (AW),
    .ALMOST_FULL_LEVEL (3),
    .IDLE_BITS         (35)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .rdata            (rdata),
    .rdata_valid      (rdata_valid),
    .rdata_error      (rdata_error),
    .fifo_dout        (fifo_dout),
    .fifo_dout_error  (fifo_dout_error),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr),
    .drop_cnt         (drop_cnt),
    .frame_end        (frame_end)
  );

  always #5 clk = ~clk;

  localparam int OpW = 0;
  localparam int OpP = 1;
  localparam int OpC = 2;

  typedef struct {
    int         op;
    logic [7:0] data;
    int         cnt;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       af;
    logic       ovf;
    int         drop;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic write_byte(input logic [7:0] d, input logic e);
    rdata = d;
    rdata_error = e;
    rdata_valid = 1'b1;
    @(negedge clk);
    rdata_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one();
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Counts frame_end pulses over n cycles; optionally injects a byte at cycle inject_at.
  task automatic run_window(input int n, input int inject_at, input logic [7:0] d,
                            output int pulses, output int last_k);
    pulses = 0;
    last_k = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) rdata_valid = 1'b0;
      if (k == inject_at) begin
        rdata = d;
        rdata_error = 1'b0;
        rdata_valid = 1'b1;
      end
      #1;
      if (frame_end) begin
        pulses++;
        last_k = k;
      end
    end
  endtask

  initial begin
    int p, lk;
    logic [7:0] exp_pops [4];
    vecs[0]  = '{OpW, 8'h01, 1, 8'h01, 0, 0, 0, 0, 0};
    vecs[1]  = '{OpW, 8'h02, 2, 8'h01, 0, 0, 0, 0, 0};
    vecs[2]  = '{OpW, 8'h03, 3, 8'h01, 0, 0, 1, 0, 0};
    vecs[3]  = '{OpW, 8'h04, 4, 8'h01, 0, 1, 1, 0, 0};
    vecs[4]  = '{OpW, 8'h05, 4, 8'h01, 0, 1, 1, 1, 1};
    vecs[5]  = '{OpW, 8'h06, 4, 8'h01, 0, 1, 1, 1, 2};
    vecs[6]  = '{OpP, 8'h00, 3, 8'h02, 0, 0, 1, 1, 2};
    vecs[7]  = '{OpP, 8'h00, 2, 8'h03, 0, 0, 0, 1, 2};
    vecs[8]  = '{OpP, 8'h00, 1, 8'h04, 0, 0, 0, 1, 2};
    vecs[9]  = '{OpP, 8'h00, 0, 8'h00, 1, 0, 0, 1, 2};
    vecs[10] = '{OpC, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0};
    exp_pops[0] = 8'h12; exp_pops[1] = 8'h13; exp_pops[2] = 8'h14; exp_pops[3] = 8'h07;

    rstn = 1'b0; rdata = '0; rdata_valid = 1'b0; rdata_error = 1'b0;
    fifo_rd_en = 1'b0; overflow_clr = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_af", 32'(fifo_almost_full), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_dout", 32'(fifo_dout), 32'd0);
    check("rst_dout_err", 32'(fifo_dout_error), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_frame_end", 32'(frame_end), 32'd0);

    // Held-high valid writes only once.
    rdata = 8'hA5; rdata_error = 1'b0; rdata_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("basic_count", 32'(fifo_count), 32'd1);
    check("basic_dout", 32'(fifo_dout), 32'hA5);
    rdata_valid = 1'b0;
    @(negedge clk);
    pop_one();
    check("basic_pop_empty", 32'(fifo_empty), 32'd1);
    check("basic_pop_dout", 32'(fifo_dout), 32'd0);

    for (int i = 0; i < 11; i++) begin
      case (vecs[i].op)
        OpW:     write_byte(vecs[i].data, 1'b0);
        OpP:     pop_one();
        default: clr_pulse();
      endcase
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_dout", i), 32'(fifo_dout), 32'(vecs[i].dout));
      check($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(vecs[i].empty));
      check($sformatf("v%0d_full", i), 32'(fifo_full), 32'(vecs[i].full));
      check($sformatf("v%0d_af", i), 32'(fifo_almost_full), 32'(vecs[i].af));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].drop));
    end

    // Write and pop in the same cycle while full.
    write_byte(8'h11, 1'b0);
    write_byte(8'h12, 1'b0);
    write_byte(8'h13, 1'b0);
    write_byte(8'h14, 1'b0);
    rdata = 8'h07; rdata_valid = 1'b1; fifo_rd_en = 1'b1;
    @(negedge clk);
    rdata_valid = 1'b0; fifo_rd_en = 1'b0;
    check("sim_count", 32'(fifo_count), 32'd4);
    check("sim_full", 32'(fifo_full), 32'd1);
    check("sim_drop", 32'(drop_cnt), 32'd0);
    check("sim_ovf", 32'(overflow), 32'd0);
    check("sim_dout", 32'(fifo_dout), 32'h12);
    @(negedge clk);
    write_byte(8'h09, 1'b0);
    check("drop1_ovf", 32'(overflow), 32'd1);
    check("drop1_cnt", 32'(drop_cnt), 32'd1);
    // Clear coincident with a second drop: set wins, count restarts at one.
    rdata = 8'h0A; rdata_valid = 1'b1; overflow_clr = 1'b1;
    @(negedge clk);
    rdata_valid = 1'b0; overflow_clr = 1'b0;
    check("clrdrop_ovf", 32'(overflow), 32'd1);
    check("clrdrop_cnt", 32'(drop_cnt), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sim_pop%0d", i), 32'(fifo_dout), 32'(exp_pops[i]));
      pop_one();
    end
    check("sim_drained", 32'(fifo_empty), 32'd1);
    clr_pulse();
    check("sim_clr_drop", 32'(drop_cnt), 32'd0);
    check("sim_clr_ovf", 32'(overflow), 32'd0);

    write_byte(8'h3C, 1'b1);
    check("err_dout", 32'(fifo_dout), 32'h3C);
    check("err_flag", 32'(fifo_dout_error), 32'd1);
    pop_one();
    check("err_flag_empty", 32'(fifo_dout_error), 32'd0);

    // Valid held high across reset release must not write.
    rdata = 8'h55; rdata_valid = 1'b1; rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rstedge_empty", 32'(fifo_empty), 32'd1);
    check("rstedge_count", 32'(fifo_count), 32'd0);
    rdata_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Idle gap: bytes 200 cycles apart, single pulse 350 cycles after the last.
    rdata = 8'h21; rdata_valid = 1'b1;
    run_window(200, 200, 8'h22, p, lk);
    check("idle_gap_early", 32'(p), 32'd0);
    run_window(400, 0, 8'h00, p, lk);
    check("idle_pulses", 32'(p), 32'd1);
    check("idle_pulse_at", 32'(lk), 32'd350);

    // Byte at C+349, then a byte on the terminal cycle: both restart without a pulse.
    @(negedge clk);
    rdata = 8'h31; rdata_valid = 1'b1;
    run_window(349, 349, 8'h32, p, lk);
    check("restart349_pulses", 32'(p), 32'd0);
    run_window(350, 350, 8'h33, p, lk);
    check("restart_term_pulses", 32'(p), 32'd0);
    run_window(400, 0, 8'h00, p, lk);
    check("restart_final_pulses", 32'(p), 32'd1);
    check("restart_final_at", 32'(lk), 32'd350);

    // Reset mid-frame discards data and the pending pulse.
    do_reset();
    write_byte(8'h41, 1'b0);
    write_byte(8'h42, 1'b0);
    write_byte(8'h43, 1'b0);
    check("mid_count_before", 32'(fifo_count), 32'd3);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("mid_empty", 32'(fifo_empty), 32'd1);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_dout", 32'(fifo_dout), 32'd0);
    run_window(400, 0, 8'h00, p, lk);
    check("mid_no_frame_end", 32'(p), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
